// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw key pins in, debounced level and pulses out.
// The master drives the raw pins; the slave is the conditioner.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic              any_press;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  any_press
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output any_press
    );
endinterface

// File: rtl/key_conditioner.sv
// N-channel push-button conditioner: synchroniser, debounce, level and press/release pulses.
// Optional auto-repeat of press pulses while held is built when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_DELAY    = 32,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input logic             Clk,
    input logic             Reset,
    key_conditioner_if.slave kif
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] s1_q, s1_d;
    logic [N_KEYS-1:0] s2_q;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic              any_q, any_d;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RptLast   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RptReload = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_q [N_KEYS];
    logic [RW-1:0] rpt_d [N_KEYS];
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    always_comb begin
        // Normalise to pressed = 1 before the synchroniser.
        s1_d      = (ACTIVE_LOW != 0) ? ~kif.key_raw : kif.key_raw;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i]     = '0;
                level_d[i]   = s2_q[i];
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
`ifdef KEY_AUTOREPEAT_EN
            rpt_d[i] = rpt_q[i];
            // A release this cycle wins over a due repeat.
            if (press_d[i] || release_d[i] || !level_q[i]) begin
                rpt_d[i] = '0;
            end else if (rpt_q[i] == RptLast) begin
                rpt_d[i]   = RptReload;
                press_d[i] = 1'b1;
            end else begin
                rpt_d[i] = rpt_q[i] + 1'b1;
            end
`endif
        end
        any_d = |press_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
`ifdef KEY_AUTOREPEAT_EN
                rpt_q[i] <= '0;
`endif
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
`ifdef KEY_AUTOREPEAT_EN
                rpt_q[i] <= rpt_d[i];
`endif
            end
        end
    end

    assign kif.key_level   = level_q;
    assign kif.key_press   = press_q;
    assign kif.key_release = release_q;
    assign kif.any_press   = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: vector table plus reset, latency and auto-repeat sequences.
module tb_key_conditioner;
    localparam int unsigned NK = 4;

    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    key_conditioner_if #(.N_KEYS(NK)) kif ();

    key_conditioner #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (32),
        .REPEAT_PERIOD   (8)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .kif   (kif.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic [NK-1:0] raw;
        int            n;
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic          any;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [NK-1:0] raw, int n, logic [NK-1:0] level,
                                logic [NK-1:0] press, logic [NK-1:0] rel, logic any);
        vec_t v;
        v.raw   = raw;
        v.n     = n;
        v.level = level;
        v.press = press;
        v.rel   = rel;
        v.any   = any;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".level"}, 32'(kif.key_level), 0);
        chk({name, ".press"}, 32'(kif.key_press), 0);
        chk({name, ".release"}, 32'(kif.key_release), 0);
        chk({name, ".any"}, 32'(kif.any_press), 0);
    endtask

    // Count edges until the chosen pulse bit rises; returns max+1 on timeout.
    task automatic wait_bit(input int b, input bit is_press, input int max, output int edges);
        edges = max + 1;
        for (int e = 1; e <= max; e++) begin
            step();
            if ((is_press ? kif.key_press[b] : kif.key_release[b]) === 1'b1) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        int edges;
        int press_offs[$];
        int exp_offs[$];
        int rel_off;

        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        kif.key_raw = '1;
        step();
        step();
        step();
        chk_all_zero("reset");
        Reset = 1'b0;

        vecs.push_back(mk(4'hF, 20, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD,  5, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD,  1, 4'h2, 4'h2, 4'h0, 1'b1));
        vecs.push_back(mk(4'hD,  1, 4'h2, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'h9,  3, 4'h2, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hD,  6, 4'h2, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'h9,  5, 4'h2, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'h9,  1, 4'h6, 4'h4, 4'h0, 1'b1));
        vecs.push_back(mk(4'h9,  1, 4'h6, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF,  5, 4'h6, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF,  1, 4'h0, 4'h0, 4'h6, 1'b0));
        vecs.push_back(mk(4'hF,  1, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'h5,  5, 4'h0, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'h5,  1, 4'hA, 4'hA, 4'h0, 1'b1));
        vecs.push_back(mk(4'h5,  1, 4'hA, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF,  5, 4'hA, 4'h0, 4'h0, 1'b0));
        vecs.push_back(mk(4'hF,  1, 4'h0, 4'h0, 4'hA, 1'b0));
        vecs.push_back(mk(4'hF,  1, 4'h0, 4'h0, 4'h0, 1'b0));

        foreach (vecs[i]) begin
            kif.key_raw = vecs[i].raw;
            for (int c = 0; c < vecs[i].n; c++) step();
            chk($sformatf("vec%0d.level", i), 32'(kif.key_level), 32'(vecs[i].level));
            chk($sformatf("vec%0d.press", i), 32'(kif.key_press), 32'(vecs[i].press));
            chk($sformatf("vec%0d.release", i), 32'(kif.key_release), 32'(vecs[i].rel));
            chk($sformatf("vec%0d.any", i), 32'(kif.any_press), 32'(vecs[i].any));
        end

        // Reset in the middle of a debounce with the key still held.
        kif.key_raw = 4'hE;
        for (int c = 0; c < 4; c++) step();
        chk("middebounce.level", 32'(kif.key_level), 0);
        Reset = 1'b1;
        step();
        step();
        chk_all_zero("inreset");
        Reset = 1'b0;
        wait_bit(0, 1'b1, 20, edges);
        chk("postreset.press_latency", 32'(edges), 6);
        chk("postreset.level", 32'(kif.key_level), 32'h1);
        chk("postreset.any", 32'(kif.any_press), 1);

        kif.key_raw = 4'hF;
        wait_bit(0, 1'b0, 20, edges);
        chk("release.latency", 32'(edges), 6);
        chk("release.level", 32'(kif.key_level), 0);

        // Hold key 3 and log every press pulse relative to the accept edge.
        kif.key_raw = 4'h7;
        wait_bit(3, 1'b1, 20, edges);
        chk("hold.accept_latency", 32'(edges), 6);
        press_offs.push_back(0);
        rel_off = -1;
        for (int off = 1; off <= 80; off++) begin
            step();
            if (kif.key_press[3] === 1'b1) press_offs.push_back(off);
            if (kif.key_release[3] === 1'b1) rel_off = off;
            if (off == 58) kif.key_raw = 4'hF;
        end
`ifdef KEY_AUTOREPEAT_EN
        exp_offs = '{0, 32, 40, 48, 56};
`else
        exp_offs = '{0};
`endif
        chk("hold.press_count", 32'(press_offs.size()), 32'(exp_offs.size()));
        foreach (exp_offs[i]) begin
            if (i < press_offs.size())
                chk($sformatf("hold.press_off%0d", i), 32'(press_offs[i]), 32'(exp_offs[i]));
        end
        chk("hold.release_off", 32'(rel_off), 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required to finish in time");
        $fatal(1, "timeout");
    end
endmodule
